code_search_ctrl: RTL and testbench

CODE_SEARCH_CTRL -- requirements
Module: code_search_ctrl

---
 rtl/code_search_if.sv | 36 +++
 rtl/code_search_ctrl.sv | 164 ++++++++++++++++
 tb/tb_code_search_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_search_if.sv
// Bus between the acquisition search controller and its environment
// (control host, code generator and correlator accumulators).
interface code_search_if;
   logic        start;
   logic        abort;
   logic [9:0]  prn_sel;
   logic [3:0]  dwell_len;
   logic [2:0]  slew_step;
   logic [20:0] threshold;
   logic        dump_enable;
   logic [15:0] accum_i;
   logic [15:0] accum_q;
   logic        prn_key_enable;
   logic [9:0]  prn_key;
   logic        slew_enable;
   logic [10:0] code_slew;
   logic        busy;
   logic        done;
   logic        found;
   logic [10:0] found_cell;
   logic [20:0] found_energy;

   modport master (
      output start, abort, prn_sel, dwell_len, slew_step, threshold,
             dump_enable, accum_i, accum_q,
      input  prn_key_enable, prn_key, slew_enable, code_slew, busy, done,
             found, found_cell, found_energy
   );

   modport slave (
      input  start, abort, prn_sel, dwell_len, slew_step, threshold,
             dump_enable, accum_i, accum_q,
      output prn_key_enable, prn_key, slew_enable, code_slew, busy, done,
             found, found_cell, found_energy
   );
endinterface

// File: rtl/code_search_ctrl.sv
// Serial code-phase search: loads a PRN key, then steps through half-chip
// cells, integrating |I|+|Q| over a dwell and stopping at the first cell
// whose energy exceeds the threshold.
module code_search_ctrl #(
   parameter int unsigned DWELL_MAX   = 15,
   parameter int unsigned N_HALFCHIPS = 2046
) (
   input logic          clk,
   input logic          rst,
   code_search_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StLoad, StSettle, StDwell, StEval, StSlew, StSkip
   } state_e;

   state_e      state_q, state_d;
   logic [9:0]  prn_key_q;
   logic [3:0]  dwell_q;
   logic [2:0]  step_q;
   logic [20:0] thr_q;
   logic [10:0] cell_q;
   logic [20:0] energy_q;
   logic [3:0]  count_q;
   logic        found_q;
   logic [10:0] found_cell_q;
   logic [20:0] found_energy_q;
   logic        done_q;
   logic [10:0] code_slew_q;

   logic [3:0]  dwell_eff;
   logic [2:0]  step_eff;
   logic [16:0] mag_i, mag_q;
   logic [20:0] energy_sum;
   logic [11:0] next_cell;
   logic        hit, last_cell, kill, dwell_end;

   // Effective settings, magnitudes and evaluation terms
   always_comb begin
      dwell_eff = bus.dwell_len;
      if (bus.dwell_len == 4'd0) begin
         dwell_eff = 4'd1;
      end else if (32'(bus.dwell_len) > DWELL_MAX) begin
         dwell_eff = 4'(DWELL_MAX);
      end
      step_eff   = (bus.slew_step == 3'd0) ? 3'd1 : bus.slew_step;
      // 17-bit magnitudes so that |-32768| is representable
      mag_i      = bus.accum_i[15] ? (17'd0 - {bus.accum_i[15], bus.accum_i})
                                   : {1'b0, bus.accum_i};
      mag_q      = bus.accum_q[15] ? (17'd0 - {bus.accum_q[15], bus.accum_q})
                                   : {1'b0, bus.accum_q};
      energy_sum = energy_q + {4'd0, mag_i} + {4'd0, mag_q};
      next_cell  = {1'b0, cell_q} + {9'd0, step_q};
      hit        = energy_q > thr_q;
      last_cell  = 32'(next_cell) >= N_HALFCHIPS;
      dwell_end  = (count_q + 4'd1) == dwell_q;
      kill       = bus.abort && (state_q != StIdle);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort wins over every other transition
   always_comb begin
      state_d = state_q;
      if (kill) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:   if (bus.start) state_d = StLoad;
            StLoad:   state_d = StSettle;
            StSettle: if (bus.dump_enable) state_d = StDwell;
            StDwell:  if (bus.dump_enable && dwell_end) state_d = StEval;
            StEval:   state_d = (hit || last_cell) ? StIdle : StSlew;
            StSlew:   state_d = StSkip;
            StSkip:   if (bus.dump_enable) state_d = StDwell;
            default:  state_d = StIdle;
         endcase
      end
   end

   // Search datapath: latched settings, integration and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         prn_key_q      <= '0;
         dwell_q        <= '0;
         step_q         <= '0;
         thr_q          <= '0;
         cell_q         <= '0;
         energy_q       <= '0;
         count_q        <= '0;
         found_q        <= 1'b0;
         found_cell_q   <= '0;
         found_energy_q <= '0;
         done_q         <= 1'b0;
         code_slew_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (!kill) begin
            unique case (state_q)
               StIdle: begin
                  if (bus.start) begin
                     prn_key_q      <= bus.prn_sel;
                     dwell_q        <= dwell_eff;
                     step_q         <= step_eff;
                     thr_q          <= bus.threshold;
                     cell_q         <= '0;
                     found_q        <= 1'b0;
                     found_cell_q   <= '0;
                     found_energy_q <= '0;
                  end
               end
               StSettle, StSkip: begin
                  // This dump spans a code reload or slew, so it is dropped
                  if (bus.dump_enable) begin
                     energy_q <= '0;
                     count_q  <= '0;
                  end
               end
               StDwell: begin
                  if (bus.dump_enable) begin
                     energy_q <= energy_sum;
                     count_q  <= count_q + 4'd1;
                  end
               end
               StEval: begin
                  if (hit) begin
                     found_q        <= 1'b1;
                     found_cell_q   <= cell_q;
                     found_energy_q <= energy_q;
                     done_q         <= 1'b1;
                  end else if (last_cell) begin
                     done_q <= 1'b1;
                  end else begin
                     cell_q      <= next_cell[10:0];
                     code_slew_q <= {8'd0, step_q};
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Outputs: strobes decoded from state, results from registers
   always_comb begin
      bus.prn_key_enable = (state_q == StLoad);
      bus.slew_enable    = (state_q == StSlew);
      bus.busy           = (state_q != StIdle);
      bus.done           = done_q;
      bus.prn_key        = prn_key_q;
      bus.code_slew      = code_slew_q;
      bus.found          = found_q;
      bus.found_cell     = found_cell_q;
      bus.found_energy   = found_energy_q;
   end

endmodule

// File: tb/tb_code_search_ctrl.sv
// Bench: emulates a code generator that reacts to load/slew strobes and
// serves dumps whose values depend on code phase; a cell-by-cell search
// model predicts the outcome of each search.
module tb_code_search_ctrl;

   localparam int NHC = 2046;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   code_search_if bus();

   code_search_ctrl #(.DWELL_MAX(15), .N_HALFCHIPS(NHC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Code generator / signal scenario
   int         g_dwell = 1, g_step = 1, g_tgt = -1;
   int         g_ti = 0, g_tq = 0, g_bi = 0, g_bq = 0, g_seed = 0;
   bit         g_noise = 1'b0;
   logic [9:0] g_key = '0;
   int         phase = 0, kidx = 0, tick = 0;
   int         load_cnt = 0, slew_cnt = 0, done_cnt = 0, dump_cnt = 0;
   int         r_found = 0, r_cell = 0, r_energy = 0;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Dump k after a strobe: k=0 spans the reload/slew, k>dwell is past the cell
   function automatic void val(input int ph, input int k, output int vi, output int vq);
      if (k == 0 || k > g_dwell) begin
         vi = 32767;
         vq = -32768;
      end else if (ph == g_tgt) begin
         vi = g_ti;
         vq = g_tq;
      end else begin
         vi = g_bi;
         vq = g_bq;
         if (g_noise) begin
            vi += ((ph * 131 + k * 17 + g_seed) % 81) - 40;
            vq += ((ph * 29 + k * 53 + g_seed * 7) % 81) - 40;
         end
      end
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Search as a list of cells 0, st, 2st, ... each scored over its dwell
   task automatic model(input int dw, input int st, input int thr,
                        output int f, output int fc, output int fe, output int sl);
      int c, e, vi, vq;
      c = 0; f = 0; fc = 0; fe = 0; sl = 0;
      for (int it = 0; it < 4096; it++) begin
         e = 0;
         for (int k = 1; k <= dw; k++) begin
            val(c, k, vi, vq);
            e += iabs(vi) + iabs(vq);
         end
         if (e > thr) begin
            f = 1; fc = c; fe = e;
            break;
         end
         if (c + st >= NHC) break;
         c += st;
         sl++;
      end
   endtask

   function automatic longint outs();
      logic [57:0] v;
      v = {bus.prn_key_enable, bus.prn_key, bus.slew_enable, bus.code_slew, bus.busy,
           bus.done, bus.found, bus.found_cell, bus.found_energy};
      return longint'(v);
   endfunction

   function automatic int rnd_hit();
      int m;
      m = int'($urandom_range(3000, 32768));
      if (m == 32768 || $urandom_range(0, 1) == 1) return -m;
      return m;
   endfunction

   // Code generator and output monitor, sampling 1 unit after each edge
   initial begin
      int vi, vq;
      bus.dump_enable = 1'b0;
      bus.accum_i = '0;
      bus.accum_q = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.prn_key_enable || bus.slew_enable || bus.done)
            check_val("strobe_excl",
                      $countones({bus.prn_key_enable, bus.slew_enable, bus.done}), 1);
         if (bus.done) begin
            done_cnt++;
            r_found  = int'(bus.found);
            r_cell   = int'(bus.found_cell);
            r_energy = int'(bus.found_energy);
         end
         tick++;
         if (tick % 5 == 0) begin
            val(phase, kidx, vi, vq);
            bus.dump_enable = 1'b1;
            bus.accum_i = 16'(vi);
            bus.accum_q = 16'(vq);
            kidx++;
            dump_cnt++;
         end else begin
            bus.dump_enable = 1'b0;
            bus.accum_i = 16'($urandom);
            bus.accum_q = 16'($urandom);
         end
         if (bus.prn_key_enable) begin
            load_cnt++;
            check_val("prn_key", bus.prn_key, g_key);
            phase = 0;
            kidx  = 0;
         end
         if (bus.slew_enable) begin
            slew_cnt++;
            check_val("code_slew", bus.code_slew, g_step);
            phase += int'(bus.code_slew);
            kidx  = 0;
         end
      end
   end

   task automatic launch(input logic [9:0] key, input int dwl, input int stp, input int thr);
      @(posedge clk);
      #2;
      load_cnt = 0; slew_cnt = 0; done_cnt = 0;
      bus.prn_sel   = key;
      bus.dwell_len = 4'(dwl);
      bus.slew_step = 3'(stp);
      bus.threshold = 21'(thr);
      bus.start     = 1'b1;
      @(posedge clk);
      #2;
      // Settings are latched; scramble them to prove it
      bus.start     = 1'b0;
      bus.prn_sel   = 10'($urandom);
      bus.dwell_len = 4'($urandom);
      bus.slew_step = 3'($urandom);
      bus.threshold = 21'($urandom);
   endtask

   task automatic run_search(input string tag, input logic [9:0] key, input int dwl,
                             input int stp, input int thr, input bit mid_start);
      int dw, st, ef, ec, ee, es;
      dw = (dwl == 0) ? 1 : dwl;
      st = (stp == 0) ? 1 : stp;
      g_dwell = dw; g_step = st; g_key = key;
      model(dw, st, thr, ef, ec, ee, es);
      launch(key, dwl, stp, thr);
      for (int n = 0; n < 30000 && done_cnt == 0; n++) begin
         bus.start = mid_start && (n == 12) && bus.busy;
         @(posedge clk);
         #2;
      end
      bus.start = 1'b0;
      check_val({tag, "_done"}, done_cnt, 1);
      check_val({tag, "_found"}, r_found, ef);
      check_val({tag, "_cell"}, r_cell, ec);
      check_val({tag, "_energy"}, r_energy, ee);
      check_val({tag, "_slews"}, slew_cnt, es);
      check_val({tag, "_loads"}, load_cnt, 1);
      repeat (3) @(posedge clk);
      #2;
      check_val({tag, "_held_found"}, bus.found, ef);
      check_val({tag, "_held_cell"}, bus.found_cell, ec);
      check_val({tag, "_one_done"}, done_cnt, 1);
   endtask

   initial begin
      int d0, st, dwl, stp;
      bit got;
      bus.start = 1'b0; bus.abort = 1'b0; bus.prn_sel = '0;
      bus.dwell_len = '0; bus.slew_step = '0; bus.threshold = '0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      check_val("por_outs", outs(), 0);

      // Immediate hit at cell 0
      g_tgt = -1; g_bi = 60; g_bq = -50; g_noise = 1'b0;
      run_search("hit", 10'b0110010110, 2, 1, 100, 1'b0);

      // Hit after three slews
      g_tgt = 9; g_ti = 300; g_tq = -300; g_bi = 0; g_bq = 0;
      run_search("slewhit", 10'h2c3, 1, 3, 500, 1'b1);

      // Exhaustive miss, and energy equal to threshold is not a hit
      g_tgt = -1; g_bi = 0; g_bq = 0;
      run_search("nohit", 10'h011, 1, 7, 0, 1'b0);
      g_bi = 60; g_bq = -50;
      run_search("eqthr", 10'h3ff, 1, 7, 110, 1'b0);

      // dwell_len=0 acts as 1, full-scale negative samples
      g_bi = -32768; g_bq = -32768;
      run_search("fullscale", 10'h155, 0, 2, 65535, 1'b0);

      // Random scenarios
      for (int r = 0; r < 8; r++) begin
         dwl = int'($urandom_range(0, 15));
         stp = int'($urandom_range(0, 7));
         st  = (stp == 0) ? 1 : stp;
         g_tgt = st * int'($urandom_range(0, 12));
         g_ti = rnd_hit(); g_tq = rnd_hit();
         g_bi = 0; g_bq = 0; g_noise = 1'b1;
         g_seed = int'($urandom_range(0, 1000));
         run_search("rnd", 10'($urandom), dwl, stp, int'($urandom_range(500, 5000)),
                    r[0]);
      end

      // Abort during SKIP on the same edge as a dump
      g_tgt = -1; g_bi = 0; g_bq = 0; g_noise = 1'b0; g_dwell = 1; g_step = 3;
      g_key = 10'h0f0;
      launch(10'h0f0, 1, 3, 0);
      for (int n = 0; n < 200 && slew_cnt == 0; n++) begin
         @(posedge clk);
         #2;
      end
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(posedge clk);
         #2;
         if (bus.dump_enable && bus.busy && !bus.slew_enable) begin
            bus.abort = 1'b1;
            got = 1'b1;
         end
      end
      check_val("abort_in_skip", got, 1);
      @(posedge clk);
      #2;
      bus.abort = 1'b0;
      check_val("abort_busy", bus.busy, 0);
      check_val("abort_found", bus.found, 0);
      check_val("abort_strobes", {bus.prn_key_enable, bus.slew_enable, bus.done}, 0);
      repeat (20) @(posedge clk);
      #2;
      check_val("abort_no_done", done_cnt, 0);
      check_val("abort_stays_idle", bus.busy, 0);

      // Reset in the middle of a dwell
      g_dwell = 15; g_step = 1; g_key = 10'h2a5;
      launch(10'h2a5, 15, 1, 21'h1fffff);
      d0 = dump_cnt;
      for (int n = 0; n < 200 && dump_cnt < d0 + 3; n++) begin
         @(posedge clk);
         #2;
      end
      check_val("rst_pre_busy", bus.busy, 1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check_val("rst_outs", outs(), 0);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      check_val("rst_no_done", done_cnt, 0);
      check_val("rst_idle", bus.busy, 0);

      // Search still works after a mid-run reset
      g_tgt = 4; g_ti = 5000; g_tq = 5000; g_bi = 0; g_bq = 0;
      run_search("postrst", 10'h0a5, 3, 4, 2000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
